// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit data-memory port.
// Sizes follow the RV32 funct3 encoding, with bit 2 selecting an unsigned load.
package lsu_pkg;

   typedef enum logic [1:0] {IDLE, LD2, ST2, LDW} lsu_state_t;

   localparam logic [1:0] SZ_B   = 2'b00;
   localparam logic [1:0] SZ_H   = 2'b01;
   localparam logic [1:0] SZ_W   = 2'b10;
   localparam int         F3_UNS = 2;

   // Request fields held across the second half of a split access.
   typedef struct packed {
      logic        uns;
      logic        split;
      logic [1:0]  size;
      logic [1:0]  off;
      logic [31:0] wdata;
   } lsu_req_t;

   function automatic logic [3:0] byte_mask(input logic [1:0] size);
      case (size)
         SZ_B:    return 4'b0001;
         SZ_H:    return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [2:0] byte_cnt(input logic [1:0] size);
      case (size)
         SZ_B:    return 3'd1;
         SZ_H:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_dmem_port_load_extend.sv
// Load data path: realigns the read word (or merges both halves of a split
// load) into the low lanes, then sign/zero-fills the lanes above the access size.
module load_extend
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rd,
   input  logic [XLEN-1:0] lo,
   input  logic [1:0]      off,
   input  logic            split,
   input  logic [1:0]      size,
   input  logic            uns,
   output logic [XLEN-1:0] data
);
   localparam int NUM_LANES = XLEN/8;

   logic [XLEN-1:0]      merged;
   logic [NUM_LANES-1:0] keep;
   logic                 fill;

   // lo already holds the 4-off upper bytes of the first word, right-justified.
   always_comb begin
      merged = split ? (lo | (rd << {3'd4 - {1'b0, off}, 3'b000}))
                     : (rd >> {off, 3'b000});
      keep   = byte_mask(size);
      fill   = ~uns & ((size == SZ_B) ? merged[7] : merged[15]);
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign data[8*i +: 8] = keep[i] ? merged[8*i +: 8] : {8{fill}};
   end

endmodule

// File: rtl/lsu_dmem_port.sv
// MEM-stage load/store port to a 1-cycle synchronous data memory. Word-crossing
// accesses are issued as two memory transactions while req_ready is held low.
module lsu_dmem_port
   import lsu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH+1:0] req_addr,
   input  logic [XLEN-1:0]       req_wdata,
   output logic                  resp_valid,
   output logic [XLEN-1:0]       resp_rdata,
   output logic                  dmem_we,
   output logic [XLEN/8-1:0]     dmem_be,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [XLEN-1:0]       dmem_wd,
   input  logic [XLEN-1:0]       dmem_rd
);
   lsu_state_t            state_q, state_d;
   lsu_req_t              req_q;
   logic [ADDR_WIDTH-1:0] nxt_q;
   logic [XLEN-1:0]       lo_q;

   logic [1:0]            size_i, off_i;
   logic [3:0]            m_i, m_q;
   logic                  split_i;
   logic [5:0]            sh_hi;
   logic [XLEN-1:0]       ext_data;

   always_comb begin
      size_i  = req_funct3[1] ? SZ_W : req_funct3[1:0];
      off_i   = req_addr[1:0];
      m_i     = byte_mask(size_i);
      split_i = ({1'b0, off_i} + byte_cnt(size_i)) > 3'd4;
      m_q     = byte_mask(req_q.size);
      sh_hi   = {3'd4 - {1'b0, req_q.off}, 3'b000};
   end

   load_extend #(.XLEN(XLEN)) u_ext (
      .rd    (dmem_rd),
      .lo    (lo_q),
      .off   (req_q.off),
      .split (req_q.split),
      .size  (req_q.size),
      .uns   (req_q.uns),
      .data  (ext_data)
   );

   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      dmem_we    = 1'b0;
      dmem_be    = '0;
      dmem_addr  = nxt_q;
      dmem_wd    = '0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            dmem_addr = req_addr[ADDR_WIDTH+1:2];
            if (req_valid) begin
               dmem_we = req_we;
               dmem_be = m_i << off_i;
               dmem_wd = req_wdata << {off_i, 3'b000};
               if (req_we) state_d = split_i ? ST2 : IDLE;
               else        state_d = split_i ? LD2 : LDW;
            end
         end
         ST2: begin
            dmem_we = 1'b1;
            dmem_be = m_q >> sh_hi[5:3];
            dmem_wd = req_q.wdata >> sh_hi;
            state_d = IDLE;
         end
         LD2: begin
            dmem_be = m_q >> sh_hi[5:3];
            state_d = LDW;
         end
         LDW: begin
            resp_valid = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Memory must see no access and upstream no acceptance while in reset.
      if (reset) begin
         dmem_we   = 1'b0;
         dmem_be   = '0;
         req_ready = 1'b0;
      end
      resp_rdata = resp_valid ? ext_data : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         req_q   <= '0;
         nxt_q   <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         if (req_valid && req_ready) begin
            req_q <= '{uns: req_funct3[F3_UNS], split: split_i, size: size_i,
                       off: off_i, wdata: req_wdata};
            nxt_q <= req_addr[ADDR_WIDTH+1:2] + 1'b1;
         end
         if (state_q == LD2) lo_q <= dmem_rd >> {req_q.off, 3'b000};
      end
   end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Bench for lsu_dmem_port: directed scenarios plus randomized traffic checked
// against a byte-array memory reference.
module tb_lsu_dmem_port;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [9:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        dmem_we;
   logic [3:0]  dmem_be;
   logic [7:0]  dmem_addr;
   logic [31:0] dmem_wd;
   logic [31:0] dmem_rd = '0;

   always #5 clk = ~clk;

   lsu_dmem_port #(.XLEN(32), .ADDR_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .dmem_we(dmem_we), .dmem_be(dmem_be),
      .dmem_addr(dmem_addr), .dmem_wd(dmem_wd), .dmem_rd(dmem_rd));

   // Synchronous memory: byte-enabled writes, registered reads.
   logic [31:0] mem_w [0:255] = '{default: 32'h0};
   always @(posedge clk) begin
      if (dmem_we) begin
         for (int i = 0; i < 4; i++)
            if (dmem_be[i]) mem_w[dmem_addr][8*i +: 8] <= dmem_wd[8*i +: 8];
      end else begin
         dmem_rd <= mem_w[dmem_addr];
      end
   end

   int wr16_cnt = 0;
   always @(posedge clk) if (dmem_we && dmem_addr == 8'h10) wr16_cnt++;

   int nvec = 0, nerr = 0;

   // Reference: flat little-endian byte memory, addresses wrap at 1024.
   logic [7:0] ref_b [0:1023] = '{default: 8'h0};

   function automatic int nbytes(input logic [2:0] f3);
      return f3[1] ? 4 : (f3[0] ? 2 : 1);
   endfunction

   function automatic logic is_split(input logic [9:0] addr, input logic [2:0] f3);
      return (int'(addr[1:0]) + nbytes(f3)) > 4;
   endfunction

   task automatic ref_store(input logic [9:0] addr, input logic [2:0] f3, input logic [31:0] wd);
      for (int k = 0; k < nbytes(f3); k++) ref_b[(int'(addr) + k) % 1024] = wd[8*k +: 8];
   endtask

   function automatic logic [31:0] ref_load(input logic [9:0] addr, input logic [2:0] f3);
      logic [31:0] v = '0;
      int n = nbytes(f3);
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_b[(int'(addr) + k) % 1024];
      if (!f3[2] && n < 4 && v[8*n-1])
         for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
      return v;
   endfunction

   // Snapshots of the memory-side outputs in the accept cycle (c0) and the next (c1).
   logic        c0_we, c1_we, c0_rdy, c1_rdy;
   logic [3:0]  c0_be, c1_be;
   logic [7:0]  c0_addr, c1_addr;
   logic [31:0] c0_wd, c1_wd;

   task automatic issue(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata,
                        output int resp_lat, output int rdy_lat);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      #1;
      c0_we = dmem_we; c0_be = dmem_be; c0_addr = dmem_addr; c0_wd = dmem_wd; c0_rdy = req_ready;
      @(negedge clk);
      req_valid = 1'b0;
      resp_lat = 0; rdy_lat = 0; rdata = '0;
      for (int k = 1; k <= 6; k++) begin
         if (k > 1) @(negedge clk);
         #1;
         if (k == 1) begin
            c1_we = dmem_we; c1_be = dmem_be; c1_addr = dmem_addr; c1_wd = dmem_wd; c1_rdy = req_ready;
         end
         if (resp_valid && resp_lat == 0) begin resp_lat = k; rdata = resp_rdata; end
         if (req_ready && rdy_lat == 0) rdy_lat = k;
         if (rdy_lat != 0) break;
      end
   endtask

   task automatic test_reset();
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 10'h10; req_wdata = 32'h1;
      #12;
      nvec++; if (dmem_we !== 1'b0) begin nerr++; $display("FAIL rst_we got %b want 0", dmem_we); end
      nvec++; if (dmem_be !== 4'b0) begin nerr++; $display("FAIL rst_be got %b want 0000", dmem_be); end
      nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL rst_resp got %b want 0", resp_valid); end
      nvec++; if (resp_rdata !== 32'h0) begin nerr++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
      req_valid = 1'b0;
      @(negedge clk); reset = 1'b0;
      @(negedge clk); #1;
      nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready got %b want 1", req_ready); end
      nvec++; if (dmem_we !== 1'b0) begin nerr++; $display("FAIL idle_we got %b want 0", dmem_we); end
   endtask

   task automatic test_word();
      logic [31:0] rd; int rl, yl;
      issue(1'b1, 3'b010, 10'h10, 32'hDEADBEEF, rd, rl, yl); ref_store(10'h10, 3'b010, 32'hDEADBEEF);
      nvec++; if (c0_we !== 1'b1 || c0_addr !== 8'd4 || c0_be !== 4'b1111 || c0_wd !== 32'hDEADBEEF) begin
         nerr++; $display("FAIL sw_word got we=%b a=%0d be=%b wd=%h want 1 4 1111 deadbeef", c0_we, c0_addr, c0_be, c0_wd); end
      nvec++; if (yl !== 1) begin nerr++; $display("FAIL sw_ready_lat got %0d want 1", yl); end
      issue(1'b0, 3'b010, 10'h10, 32'h0, rd, rl, yl);
      nvec++; if (c0_we !== 1'b0 || c0_addr !== 8'd4 || c0_be !== 4'b1111) begin
         nerr++; $display("FAIL lw_access got we=%b a=%0d be=%b want 0 4 1111", c0_we, c0_addr, c0_be); end
      nvec++; if (rl !== 1) begin nerr++; $display("FAIL lw_resp_lat got %0d want 1", rl); end
      nvec++; if (rd !== 32'hDEADBEEF) begin nerr++; $display("FAIL lw_data got %h want deadbeef", rd); end
      nvec++; if (yl !== 2) begin nerr++; $display("FAIL lw_ready_lat got %0d want 2", yl); end
   endtask

   task automatic test_byte_half();
      logic [31:0] rd; int rl, yl;
      issue(1'b1, 3'b010, 10'h20, 32'h00008080, rd, rl, yl); ref_store(10'h20, 3'b010, 32'h00008080);
      issue(1'b0, 3'b000, 10'h21, 32'h0, rd, rl, yl);
      nvec++; if (rd !== 32'hFFFFFF80) begin nerr++; $display("FAIL lb_sext got %h want ffffff80", rd); end
      nvec++; if (c0_be !== 4'b0010) begin nerr++; $display("FAIL lb_be got %b want 0010", c0_be); end
      issue(1'b0, 3'b100, 10'h21, 32'h0, rd, rl, yl);
      nvec++; if (rd !== 32'h00000080) begin nerr++; $display("FAIL lbu_zext got %h want 00000080", rd); end
      issue(1'b0, 3'b001, 10'h20, 32'h0, rd, rl, yl);
      nvec++; if (rd !== 32'hFFFF8080) begin nerr++; $display("FAIL lh_sext got %h want ffff8080", rd); end
   endtask

   task automatic test_split();
      logic [31:0] rd; int rl, yl;
      issue(1'b1, 3'b010, 10'h06, 32'hAABBCCDD, rd, rl, yl); ref_store(10'h06, 3'b010, 32'hAABBCCDD);
      nvec++; if (c0_we !== 1'b1 || c0_addr !== 8'd1 || c0_be !== 4'b1100 || c0_wd !== 32'hCCDD0000) begin
         nerr++; $display("FAIL sw_split_lo got we=%b a=%0d be=%b wd=%h want 1 1 1100 ccdd0000", c0_we, c0_addr, c0_be, c0_wd); end
      nvec++; if (c1_we !== 1'b1 || c1_addr !== 8'd2 || c1_be !== 4'b0011 || c1_wd !== 32'h0000AABB) begin
         nerr++; $display("FAIL sw_split_hi got we=%b a=%0d be=%b wd=%h want 1 2 0011 0000aabb", c1_we, c1_addr, c1_be, c1_wd); end
      nvec++; if (c1_rdy !== 1'b0) begin nerr++; $display("FAIL sw_split_stall got %b want 0", c1_rdy); end
      nvec++; if (yl !== 2) begin nerr++; $display("FAIL sw_split_ready_lat got %0d want 2", yl); end
      issue(1'b0, 3'b010, 10'h06, 32'h0, rd, rl, yl);
      nvec++; if (rl !== 2 || rd !== 32'hAABBCCDD) begin
         nerr++; $display("FAIL lw_split got lat=%0d data=%h want 2 aabbccdd", rl, rd); end
   endtask

   task automatic test_wrap();
      logic [31:0] rd; int rl, yl;
      issue(1'b1, 3'b001, 10'h3FF, 32'h00001234, rd, rl, yl); ref_store(10'h3FF, 3'b001, 32'h00001234);
      nvec++; if (c0_addr !== 8'd255 || c0_be !== 4'b1000 || c0_wd[31:24] !== 8'h34) begin
         nerr++; $display("FAIL sh_wrap_lo got a=%0d be=%b wd=%h want 255 1000 34xxxxxx", c0_addr, c0_be, c0_wd); end
      nvec++; if (c1_we !== 1'b1 || c1_addr !== 8'd0 || c1_be !== 4'b0001 || c1_wd[7:0] !== 8'h12) begin
         nerr++; $display("FAIL sh_wrap_hi got we=%b a=%0d be=%b wd=%h want 1 0 0001 xxxxxx12", c1_we, c1_addr, c1_be, c1_wd); end
      issue(1'b0, 3'b101, 10'h3FF, 32'h0, rd, rl, yl);
      nvec++; if (rd !== 32'h00001234) begin nerr++; $display("FAIL lhu_wrap got %h want 00001234", rd); end
   endtask

   task automatic test_reset_mid_split();
      int resp_cnt = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 10'h06;
      @(negedge clk);
      req_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      nvec++; if (dmem_we !== 1'b0 || dmem_be !== 4'b0) begin
         nerr++; $display("FAIL mid_rst_dmem got we=%b be=%b want 0 0000", dmem_we, dmem_be); end
      @(negedge clk); reset = 1'b0;
      #1;
      nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL mid_rst_ready got %b want 1", req_ready); end
      for (int k = 0; k < 4; k++) begin
         if (resp_valid) resp_cnt++;
         @(negedge clk); #1;
      end
      nvec++; if (resp_cnt !== 0) begin nerr++; $display("FAIL mid_rst_resp got %0d pulses want 0", resp_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; int rl, yl; int base;
      base = wr16_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 10'h0A; req_wdata = 32'h11223344;
      #1;
      nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL b2b_first_ready got %b want 1", req_ready); end
      ref_store(10'h0A, 3'b010, 32'h11223344);
      @(negedge clk);
      req_funct3 = 3'b000; req_addr = 10'h41; req_wdata = 32'h0000005A;
      #1;
      nvec++; if (req_ready !== 1'b0 || dmem_addr !== 8'd3 || dmem_be !== 4'b0011 || dmem_wd !== 32'h00001122) begin
         nerr++; $display("FAIL b2b_st2 got rdy=%b a=%0d be=%b wd=%h want 0 3 0011 00001122", req_ready, dmem_addr, dmem_be, dmem_wd); end
      @(negedge clk); #1;
      nvec++; if (req_ready !== 1'b1 || dmem_addr !== 8'h10 || dmem_be !== 4'b0010 || dmem_wd !== 32'h00005A00) begin
         nerr++; $display("FAIL b2b_second got rdy=%b a=%0d be=%b wd=%h want 1 16 0010 00005a00", req_ready, dmem_addr, dmem_be, dmem_wd); end
      ref_store(10'h41, 3'b000, 32'h0000005A);
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      nvec++; if (wr16_cnt - base !== 1) begin nerr++; $display("FAIL b2b_once got %0d writes want 1", wr16_cnt - base); end
      issue(1'b0, 3'b010, 10'h0A, 32'h0, rd, rl, yl);
      nvec++; if (rd !== 32'h11223344) begin nerr++; $display("FAIL b2b_lw got %h want 11223344", rd); end
      issue(1'b0, 3'b100, 10'h41, 32'h0, rd, rl, yl);
      nvec++; if (rd !== 32'h0000005A) begin nerr++; $display("FAIL b2b_lbu got %h want 0000005a", rd); end
   endtask

   task automatic test_random();
      logic [31:0] rd, wd, exp; int rl, yl, sz, sp;
      logic [2:0] f3; logic [9:0] addr; logic we;
      for (int i = 0; i < 80; i++) begin
         we   = 1'($urandom_range(0, 1));
         sz   = $urandom_range(0, 2);
         f3   = {1'($urandom_range(0, 1)), (sz == 2) ? 2'b10 : 2'(sz)};
         addr = ($urandom_range(0, 1) ? 10'h000 : 10'h3E0) + 10'($urandom_range(0, 31));
         wd   = $urandom;
         sp   = is_split(addr, f3) ? 1 : 0;
         exp  = ref_load(addr, f3);
         issue(we, f3, addr, wd, rd, rl, yl);
         if (we) begin
            ref_store(addr, f3, wd);
            nvec++; if (rl !== 0 || yl !== 1 + sp) begin
               nerr++; $display("FAIL rnd_st #%0d a=%h f3=%b got resp=%0d rdy=%0d want 0 %0d", i, addr, f3, rl, yl, 1 + sp); end
         end else begin
            nvec++; if (rd !== exp || rl !== 1 + sp || yl !== 2 + sp) begin
               nerr++; $display("FAIL rnd_ld #%0d a=%h f3=%b got %h lat=%0d rdy=%0d want %h %0d %0d", i, addr, f3, rd, rl, yl, exp, 1 + sp, 2 + sp); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte_half();
      test_split();
      test_wrap();
      test_reset_mid_split();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of test sequence");
      $fatal(1);
   end

endmodule
